// File: rtl/note_sequencer.sv
// note_sequencer: steps through a note ROM and drives PWM period/duty with timed notes, gaps and end-of-song handling
module note_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int TICK_CYCLES = 25000,
    parameter int GAP_TICKS   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [2:0]        volume,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [20:0]       period,
    output logic [20:0]       duty_cycle,
    output logic              busy,
    output logic              note_strobe,
    output logic              done
);
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [10:0]   dur;
    logic [20:0]   period_f;
    logic [10:0]   dur_f;
    logic [3:0]    vol1;
    logic [20:0]   duty_n;
    logic          wrap;
    logic          last;

    assign period_f = rom_data[31:11];
    assign dur_f    = rom_data[10:0];
    assign vol1     = {1'b0, volume} + 4'd1;
    assign duty_n   = 21'((24'(period_f) * 24'(vol1)) >> 4);
    assign wrap     = tick == TW'(TICK_CYCLES - 1);
    assign last     = wrap && dur == 11'd1;

    // dur counts note ticks in PLAY and is reloaded with GAP_TICKS to time the silence in GAP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rom_addr    <= '0;
            period      <= '0;
            duty_cycle  <= '0;
            busy        <= 1'b0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
            tick        <= '0;
            dur         <= '0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop && state != IDLE) begin
                state      <= IDLE;
                rom_addr   <= '0;
                period     <= '0;
                duty_cycle <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !stop) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        rom_addr <= '0;
                    end
                    FETCH: state <= LOAD;
                    LOAD: if (period_f == '0 && dur_f == '0) begin
                        rom_addr <= '0;
                        if (loop_en) begin
                            state <= FETCH;
                        end else begin
                            state      <= IDLE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            period     <= '0;
                            duty_cycle <= '0;
                        end
                    end else begin
                        period      <= period_f;
                        duty_cycle  <= dur_f == '0 ? '0 : duty_n;
                        note_strobe <= 1'b1;
                        tick        <= '0;
                        dur         <= dur_f != '0 ? dur_f : 11'(GAP_TICKS);
                        state       <= dur_f != '0 ? PLAY : (GAP_TICKS == 0 ? FETCH : GAP);
                        rom_addr    <= (dur_f == '0 && GAP_TICKS == 0) ? rom_addr + 1'b1 : rom_addr;
                    end
                    PLAY: begin
                        tick <= wrap ? '0 : tick + 1'b1;
                        dur  <= wrap ? dur - 11'd1 : dur;
                        if (last) begin
                            duty_cycle <= '0;
                            tick       <= '0;
                            dur        <= 11'(GAP_TICKS);
                            state      <= GAP_TICKS == 0 ? FETCH : GAP;
                            rom_addr   <= GAP_TICKS == 0 ? rom_addr + 1'b1 : rom_addr;
                        end
                    end
                    GAP: begin
                        tick <= wrap ? '0 : tick + 1'b1;
                        dur  <= wrap ? dur - 11'd1 : dur;
                        if (last) begin
                            state    <= FETCH;
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: random and directed songs checked cycle by cycle against a note-expansion model
module tb_note_sequencer;
    localparam int T1 = 4, G1 = 1, T2 = 2, G2 = 0;

    logic        clk = 0, reset = 0;
    logic        start = 0, stop = 0, start2 = 0, stop2 = 0, loop_en = 0;
    logic [2:0]  volume = 0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data, rom_data2;
    logic [20:0] period, duty_cycle, period2, duty_cycle2;
    logic        busy, note_strobe, done, busy2, note_strobe2, done2;
    logic [1:0]  rom_addr2;

    logic [31:0] song [256];
    logic [2:0]  vs [4096];
    int          checks = 0, passed = 0, fails = 0;
    bit          sel = 0;

    typedef logic [52:0] rec_t;
    rec_t q[$];

    note_sequencer #(.ADDR_W(8), .TICK_CYCLES(T1), .GAP_TICKS(G1)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .volume(volume), .rom_addr(rom_addr), .rom_data(rom_data), .period(period),
        .duty_cycle(duty_cycle), .busy(busy), .note_strobe(note_strobe), .done(done)
    );

    note_sequencer #(.ADDR_W(2), .TICK_CYCLES(T2), .GAP_TICKS(G2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2), .loop_en(loop_en),
        .volume(volume), .rom_addr(rom_addr2), .rom_data(rom_data2), .period(period2),
        .duty_cycle(duty_cycle2), .busy(busy2), .note_strobe(note_strobe2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= song[rom_addr];
        rom_data2 <= song[{6'd0, rom_addr2}];
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic rec_t mk(int a, int p, int d, bit b, bit s, bit dn);
        return {8'(a), 21'(p), 21'(d), b, s, dn};
    endfunction

    function automatic rec_t obs();
        return sel ? mk(int'(rom_addr2), int'(period2), int'(duty_cycle2), busy2, note_strobe2, done2)
                   : mk(int'(rom_addr), int'(period), int'(duty_cycle), busy, note_strobe, done);
    endfunction

    task automatic check(input string tag, input rec_t o, input rec_t e);
        checks++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Expected outputs after each clock edge, edge 0 being the one that samples start
    task automatic build(input bit lp, input int lim, input int T, input int G, input int AW);
        int a, p, d, pf, df;
        logic [31:0] e;
        q.delete();
        a = 0; p = 0; d = 0;
        while (q.size() < lim) begin
            q.push_back(mk(a, p, d, 1, 0, 0));
            q.push_back(mk(a, p, d, 1, 0, 0));
            e  = song[a];
            pf = int'(e[31:11]);
            df = int'(e[10:0]);
            if (pf == 0 && df == 0) begin
                if (!lp) begin
                    q.push_back(mk(0, 0, 0, 0, 0, 1));
                    q.push_back(mk(0, 0, 0, 0, 0, 0));
                    return;
                end
                a = 0;
            end else begin
                p = pf;
                d = (pf * (int'(vs[q.size()]) + 1)) / 16;
                for (int i = 0; i < df * T; i++) q.push_back(mk(a, p, d, 1, i == 0, 0));
                d = 0;
                for (int i = 0; i < G * T; i++) q.push_back(mk(a, p, d, 1, 0, 0));
                a = (a + 1) % (1 << AW);
            end
        end
        while (q.size() > lim) void'(q.pop_back());
    endtask

    task automatic run(input bit lp, input int lim, input int fv);
        bit s;
        for (int i = 0; i < 4096; i++) vs[i] = fv < 0 ? 3'($urandom) : 3'(fv);
        build(lp, lim, sel ? T2 : T1, sel ? G2 : G1, sel ? 2 : 8);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            s = k == 0 ? 1'b1 : (q[k-1][2] && $urandom_range(7) == 0);
            if (sel) start2 = s; else start = s;
            volume  = vs[k];
            loop_en = lp;
            @(posedge clk); #1;
            check($sformatf("cyc%0d", k), obs(), q[k]);
        end
        @(negedge clk);
        start = 0; start2 = 0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        if (sel) stop2 = 1; else stop = 1;
        @(posedge clk); #1;
        check("stop", obs(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        stop = 0; stop2 = 0;
        @(posedge clk); #1;
        check("idle_after_stop", obs(), mk(0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        int n, pf;
        for (int i = 0; i < 256; i++) song[i] = '0;
        #12;
        sel = 0; check("reset_state", obs(), mk(0, 0, 0, 0, 0, 0));
        sel = 1; check("reset_state2", obs(), mk(0, 0, 0, 0, 0, 0));
        sel = 0;
        @(negedge clk); reset = 1;

        song[0] = {21'd1000, 11'd3}; song[1] = '0;
        run(0, 1000, 7);

        song[0] = {21'd1600, 11'd1}; song[1] = '0;
        run(0, 1000, 0);
        run(0, 1000, 3);

        song[0] = {21'd0, 11'd2}; song[1] = {21'd800, 11'd1}; song[2] = '0;
        run(0, 1000, 7);

        song[0] = {21'd1200, 11'd2}; song[1] = {21'd300, 11'd1}; song[2] = '0;
        run(1, 90, -1);
        do_stop();

        song[0] = {21'd1000, 11'd3}; song[1] = '0;
        run(0, 6, -1);
        do_stop();

        @(negedge clk); start = 1; stop = 1;
        @(posedge clk); #1;
        check("start_stop_same", obs(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk); start = 0; stop = 0;
        @(posedge clk); #1;
        check("start_stop_idle", obs(), mk(0, 0, 0, 0, 0, 0));

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                pf = $urandom_range(3) == 0 ? 0 : $urandom_range(1, 2097151);
                song[i] = {21'(pf), 11'($urandom_range(1, 4))};
            end
            song[n] = '0;
            run(0, 4000, -1);
        end

        song[0] = {21'd1000, 11'd3}; song[1] = '0;
        run(0, 7, 7);
        #2 reset = 0;
        #1 check("async_reset", obs(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk); reset = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_resume", obs(), mk(0, 0, 0, 0, 0, 0));
        end

        sel = 1;
        for (int i = 0; i < 4; i++) song[i] = {21'($urandom_range(1, 2097151)), 11'($urandom_range(1, 2))};
        run(0, 60, -1);
        do_stop();
        sel = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
